pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5; number of pipeline stages, where stage 0 is fetch/PC and STAGES-1 is write-back.
REQ-002 SHALL have parameter ADDR_W, default 32; instruction address width.
REQ-003 SHALL have port clk, in, 1; the single clock, rising edge.
REQ-004 SHALL have port rst, in, 1; one clock, reset synchronous and active-low.
REQ-005 SHALL have port stallreq_i, in, STAGES; bit k is a stall request from stage k.
REQ-006 SHALL have port flush_i, in, 1; level flush request, for example an exception or redirect.
REQ-007 SHALL have port flush_pc_i, in, ADDR_W; redirect target, sampled while flush_i=1.
REQ-008 SHALL have port stall_o, out, STAGES+1; bit 0 holds the PC, and bit j+1 holds the pipeline register feeding stage j+1.
REQ-009 SHALL have port flush_o, out, 1; one-cycle flush pulse to all pipeline registers.
REQ-010 SHALL have port new_pc_o, out, ADDR_W; redirect PC, valid while flush_o=1.
REQ-011 SHALL have port valid_o, out, STAGES; registered per-stage instruction-valid bits.
REQ-012 SHALL have port stall_cnt_o, out, 32; stall-cycle performance count (see Configuration).

Function
REQ-013 stall_o SHALL be combinational from stallreq_i and flush_o, with zero-cycle latency.
REQ-014 SHALL define h as the highest index with stallreq_i[h]=1; then stall_o[h+1:0] is all 1s and the bits above are 0.
REQ-015 With no stall request and flush_o=0, stall_o SHALL be all 0.
REQ-016 While flush_o=1, stall_o SHALL be forced to all 0, regardless of stallreq_i.
REQ-017 On each clock edge where flush_i=1, flush_o SHALL be 1 and new_pc_o SHALL equal flush_pc_i in the next cycle (1-cycle registered latency).
REQ-018 flush_o SHALL be 0 in any cycle following a cycle with flush_i=0.
REQ-019 When flush_i is held for N cycles, flush_o SHALL be high for N consecutive cycles.
REQ-020 At an edge with flush_i=1, valid_o SHALL be cleared to all 0; flush has priority over stall.
REQ-021 At an edge with no flush and no stall: valid_o[0] SHALL become 1 and valid_o[j] SHALL become the previous valid_o[j-1].
REQ-022 At an edge with stall at level h: valid_o[h:0] SHALL hold, valid_o[h+1] SHALL become 0 (bubble), and valid_o[j] for j>h+1 SHALL become the previous valid_o[j-1].
REQ-023 When h=STAGES-1, the whole pipeline SHALL hold and no bubble SHALL be inserted.
REQ-024 A stall request arriving in the same cycle as flush_o=1 SHALL be ignored for both stall_o and valid_o.

Reset
REQ-025 At a rising edge with rst=0: valid_o=0, flush_o=0, new_pc_o=0, stall_cnt_o=0.
REQ-026 Reset SHALL override flush and stall in the same cycle.
REQ-027 stall_o SHALL read all 0 while in reset.
REQ-028 Reset asserted in the middle of a flush sequence or a stall sequence SHALL terminate it with no residual pulse.

Configuration
REQ-029 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o SHALL increment by 1 on each edge where stall_o[0]=1 and flush_o=0, saturating at 32'hFFFF_FFFF.
REQ-030 Macro PIPE_CTRL_PERF_EN undefined: stall_cnt_o SHALL be constant 0, with no counter flops.

Structure
REQ-031 Shared package openmips_pkg SHALL hold the STAGES default, the ADDR_W default, and the stall-vector width constant.
REQ-032 The highest-set-bit priority encoder SHALL be sub-module prio_enc, parametrised by width, with outputs idx and any.

Verification (STAGES=5, ADDR_W=32)
REQ-033 Release reset, with no requests for 6 cycles -> valid_o ramps 00001, 00011, ... up to 11111; stall_o=0; stall_cnt_o=0.
REQ-034 stallreq_i=00010 for 1 cycle with pipeline full -> stall_o=000111; next cycle valid_o=11011; stall_cnt_o=1 (PERF_EN defined).
REQ-035 stallreq_i=00110 -> stall_o=001111, where stage 2 dominates; stallreq_i=10000 -> stall_o=111111 and valid_o unchanged after the edge.
REQ-036 flush_i=1 with flush_pc_i=32'h0000_0100 and stallreq_i=01000 in the same cycle -> next cycle flush_o=1, new_pc_o=32'h100, stall_o=0, valid_o=0.
REQ-037 flush_i held 3 cycles -> flush_o high exactly 3 cycles; a stall during those cycles leaves stall_cnt_o unchanged.
REQ-038 rst=0 asserted mid-stall with stall_cnt_o=7 -> next edge valid_o=0 and stall_cnt_o=0; with PERF_EN undefined, stall_cnt_o is 0 throughout.

Source files
------------

// File: rtl/openmips_pkg.sv
// rtl/openmips_pkg.sv - shared pipeline-control defaults and width helpers
package openmips_pkg;

  localparam int STAGES_DEF  = 5;
  localparam int ADDR_W_DEF  = 32;
  localparam int STALL_W_DEF = STAGES_DEF + 1;

  // Stall vector carries one extra bit for the PC in front of stage 0.
  function automatic int stall_width(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush request and control bundle between stages and pipe_ctrl
interface pipe_ctrl_if
  import openmips_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [STAGES-1:0] stallreq_i;
  logic              flush_i;
  logic [ADDR_W-1:0] flush_pc_i;
  logic [STAGES:0]   stall_o;
  logic              flush_o;
  logic [ADDR_W-1:0] new_pc_o;
  logic [STAGES-1:0] valid_o;
  logic [31:0]       stall_cnt_o;

  modport master (
    output stallreq_i, flush_i, flush_pc_i,
    input  stall_o, flush_o, new_pc_o, valid_o, stall_cnt_o
  );

  modport slave (
    input  stallreq_i, flush_i, flush_pc_i,
    output stall_o, flush_o, new_pc_o, valid_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_prio_enc.sv
// rtl/pipe_ctrl_prio_enc.sv - highest-set-bit priority encoder
module prio_enc #(
  parameter  int WIDTH = 5,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i_req[k]) begin
        idx = IDX_W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller; PIPE_CTRL_PERF_EN enables the stall-cycle counter
module pipe_ctrl
  import openmips_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.slave    bus
);

  localparam int IDX_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int STALL_W = stall_width(STAGES);

  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic [STALL_W-1:0] w_stall;
  logic [STAGES-1:0]  w_shift;
  logic [STAGES-1:0]  w_valid_nxt;

  logic               r_flush;
  logic [ADDR_W-1:0]  r_new_pc;
  logic [STAGES-1:0]  r_valid;

  prio_enc #(.WIDTH(STAGES)) u_prio_enc (
    .i_req (bus.stallreq_i),
    .idx   (w_idx),
    .any   (w_any)
  );

  // A flush in progress (or reset) masks every stall request.
  always_comb begin
    w_stall = '0;
    if (rst && !r_flush && w_any) begin
      for (int j = 0; j < STALL_W; j++) begin
        if (j <= int'(w_idx) + 1) w_stall[j] = 1'b1;
      end
    end
  end

  assign w_shift = {r_valid[STAGES-2:0], 1'b1};

  // Held stages keep their bit, the first unheld stage gets a bubble, the rest advance.
  always_comb begin
    w_valid_nxt = '0;
    for (int j = 0; j < STAGES; j++) begin
      if (w_stall[j+1])  w_valid_nxt[j] = r_valid[j];
      else if (w_stall[j]) w_valid_nxt[j] = 1'b0;
      else               w_valid_nxt[j] = w_shift[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_flush  <= 1'b0;
      r_new_pc <= '0;
      r_valid  <= '0;
    end else begin
      r_flush <= bus.flush_i;
      if (bus.flush_i) r_new_pc <= bus.flush_pc_i;
      r_valid <= bus.flush_i ? '0 : w_valid_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall[0] && !r_flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
`else
  assign bus.stall_cnt_o = '0;
`endif

  assign bus.stall_o  = w_stall;
  assign bus.flush_o  = r_flush;
  assign bus.new_pc_o = r_new_pc;
  assign bus.valid_o  = r_valid;

endmodule
